// File: rtl/scu_dsp_dma_port_pkg.sv
// Shared types and helpers for the SCU-side DSP DMA responder.
// Holds the FSM state encoding and the write-address increment decode.
package scu_dsp_dma_port_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    BUS,
    ACKW,
    ENDH
  } DspDmaState_t;

  // DMA_ADD code 0 means "no advance"; codes 1..7 step by 1..64 words.
  function automatic logic [6:0] DmaAddInc(input logic [2:0] code);
    logic [6:0] inc;
    inc = 7'd0;
    if (code != 3'd0) begin
      inc = 7'd1 << (code - 3'd1);
    end
    return inc;
  endfunction

endpackage

// File: rtl/scu_dsp_dma_port.sv
// Services DSP D0-bus DMA word requests as single external bus accesses,
// owning the RA0/WA0 word-address registers and the ACK/END handshake.
module scu_dsp_dma_port
  import scu_dsp_dma_port_pkg::*;
#(
  parameter int ADDR_W = 27
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE_R,
  input  logic              CE_F,
  input  logic [31:0]       DSO,
  input  logic              RA0W,
  input  logic              WA0W,
  input  logic              DMA_REQ,
  input  logic              DMA_WE,
  input  logic              DMA_RUN,
  input  logic              DMA_LAST,
  input  logic [2:0]        DMA_ADD,
  input  logic [31:0]       DMA_DO,
  output logic [31:0]       DMA_DI,
  output logic              DMA_ACK,
  output logic              DMA_END,
  output logic [ADDR_W-1:0] BUS_A,
  output logic [31:0]       BUS_D,
  input  logic [31:0]       BUS_Q,
  output logic              BUS_WE,
  output logic              BUS_REQ,
  input  logic              BUS_ACK,
  output logic              BUSY,
  output logic [ADDR_W-3:0] RA0_Q,
  output logic [ADDR_W-3:0] WA0_Q
);

  localparam int AW = ADDR_W - 2;

  DspDmaState_t state_reg, state_next;
  logic          dir_reg;
  logic          abort_reg, abort_next;
  logic [AW-1:0] ra0_reg, wa0_reg;
  logic [31:0]   dma_di_reg, bus_d_reg;
  logic          ld_dir, ld_bus_d, bus_done, dma_ack;
  logic [AW-1:0] wa0_inc;
  logic          unused_dso_hi;

  assign unused_dso_hi = ^DSO[31:AW];
  assign wa0_inc       = {{(AW-7){1'b0}}, DmaAddInc(DMA_ADD)};

  always_comb begin
    state_next = state_reg;
    abort_next = abort_reg;
    ld_dir     = 1'b0;
    ld_bus_d   = 1'b0;
    bus_done   = 1'b0;
    dma_ack    = 1'b0;
    case (state_reg)
      IDLE: begin
        abort_next = 1'b0;
        if (DMA_RUN && DMA_REQ) begin
          state_next = FETCH;
          ld_dir     = 1'b1;
        end
      end
      FETCH: begin
        if (!DMA_RUN) begin
          state_next = IDLE;
        end else begin
          state_next = BUS;
          ld_bus_d   = dir_reg;
        end
      end
      BUS: begin
        // An abort seen at any point during the access is remembered so the
        // word is never acknowledged, even if DMA_RUN returns before BUS_ACK.
        if (!DMA_RUN) begin
          abort_next = 1'b1;
        end
        if (BUS_ACK) begin
          bus_done   = 1'b1;
          state_next = (abort_reg || !DMA_RUN) ? IDLE : ACKW;
        end
      end
      ACKW: begin
        if (!DMA_RUN) begin
          state_next = IDLE;
        end else if (CE_R) begin
          dma_ack    = 1'b1;
          state_next = DMA_LAST ? ENDH : IDLE;
        end
      end
      ENDH: begin
        if (CE_F) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= IDLE;
      dir_reg    <= 1'b0;
      abort_reg  <= 1'b0;
      ra0_reg    <= '0;
      wa0_reg    <= '0;
      dma_di_reg <= '0;
      bus_d_reg  <= '0;
    end else begin
      state_reg <= state_next;
      abort_reg <= abort_next;
      if (ld_dir) begin
        dir_reg <= DMA_WE;
      end
      if (ld_bus_d) begin
        bus_d_reg <= DMA_DO;
      end
      if (bus_done && !dir_reg) begin
        dma_di_reg <= BUS_Q;
      end
      if (RA0W) begin
        ra0_reg <= DSO[AW-1:0];
      end else if (bus_done && !dir_reg) begin
        ra0_reg <= ra0_reg + 1'b1;
      end
      if (WA0W) begin
        wa0_reg <= DSO[AW-1:0];
      end else if (bus_done && dir_reg) begin
        wa0_reg <= wa0_reg + wa0_inc;
      end
    end
  end

  assign DMA_ACK = dma_ack;
  assign DMA_END = (state_reg == ENDH);
  assign DMA_DI  = dma_di_reg;
  assign BUS_REQ = (state_reg == BUS);
  assign BUS_WE  = (state_reg == BUS) && dir_reg;
  assign BUS_A   = {(dir_reg ? wa0_reg : ra0_reg), 2'b00};
  assign BUS_D   = bus_d_reg;
  assign BUSY    = (state_reg != IDLE);
  assign RA0_Q   = ra0_reg;
  assign WA0_Q   = wa0_reg;

endmodule
